// File: rtl/clkdiv_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clkdiv_reset_sequencer: PLL lock / CLKDIV reset bring-up and alive monitor |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module clkdiv_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DIV_SETTLE_CYCLES  = 16,
  parameter int ALIVE_TIMEOUT      = 256,
  parameter int ALIVE_EDGES        = 4,
  parameter int CNT_W              = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       div_toggle,
  output logic       div_resetn,
  output logic       sys_reset,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam logic [2:0] S_RESET       = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK   = 3'd1;
  localparam logic [2:0] S_LOCK_STABLE = 3'd2;
  localparam logic [2:0] S_DIV_SETTLE  = 3'd3;
  localparam logic [2:0] S_CHECK_ALIVE = 3'd4;
  localparam logic [2:0] S_RUN         = 3'd5;

  localparam int EW = $clog2(ALIVE_EDGES + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DIV_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALIVE_LAST  = CNT_W'(ALIVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [EW-1:0]    EDGES_NEED  = EW'(ALIVE_EDGES);

  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;
  logic [2:0]       tog_sync_q, tog_sync_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             div_resetn_q, div_resetn_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;

  logic             edge_p;
  logic [EW-1:0]    edge_cnt_nxt;
  logic [3:0]       retry_inc;

  always_comb begin
    lock_meta_d  = pll_lock;
    lock_s_d     = lock_meta_q;
    tog_sync_d   = {tog_sync_q[1:0], div_toggle};
    // Any change between the two settled stages is one divided-clock edge.
    edge_p       = tog_sync_q[2] ^ tog_sync_q[1];
    edge_cnt_nxt = edge_cnt_q + EW'(edge_p);
    retry_inc    = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    retry_d    = retry_q;

    case (state_q)
      S_RESET: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end

      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s_q) begin
          state_d = S_LOCK_STABLE;
        end
      end

      S_LOCK_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_DIV_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DIV_SETTLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d    = S_CHECK_ALIVE;
          cnt_d      = '0;
          edge_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_CHECK_ALIVE: begin
        // Lock loss outranks both success and timeout and never counts as a retry.
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (edge_cnt_nxt == EDGES_NEED) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          edge_cnt_d = edge_cnt_nxt;
        end else if (cnt_q == ALIVE_LAST) begin
          state_d = S_WAIT_LOCK;
          retry_d = retry_inc;
        end else begin
          cnt_d      = cnt_q + CNT_ONE;
          edge_cnt_d = edge_cnt_nxt;
        end
      end

      S_RUN: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (edge_p) begin
          cnt_d = '0;
        end else if (cnt_q == ALIVE_LAST) begin
          state_d = S_WAIT_LOCK;
          retry_d = retry_inc;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they switch on the same edge as the FSM.
    div_resetn_d = (state_d == S_DIV_SETTLE) || (state_d == S_CHECK_ALIVE) ||
                   (state_d == S_RUN);
    sys_reset_d  = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      tog_sync_q   <= 3'b000;
      state_q      <= S_RESET;
      cnt_q        <= '0;
      edge_cnt_q   <= '0;
      retry_q      <= 4'd0;
      div_resetn_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      lock_meta_q  <= lock_meta_d;
      lock_s_q     <= lock_s_d;
      tog_sync_q   <= tog_sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      retry_q      <= retry_d;
      div_resetn_q <= div_resetn_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
    end
  end

  assign div_resetn  = div_resetn_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_clkdiv_reset_sequencer: randomized bench against a cycle-level model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_clkdiv_reset_sequencer;

  localparam int LS = 8;
  localparam int DS = 4;
  localparam int AT = 16;
  localparam int AE = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       div_toggle;
  logic       div_resetn;
  logic       sys_reset;
  logic       ready;
  logic [3:0] retry_count;
  logic [2:0] state;

  clkdiv_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LS),
    .DIV_SETTLE_CYCLES (DS),
    .ALIVE_TIMEOUT     (AT),
    .ALIVE_EDGES       (AE),
    .CNT_W             (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .div_toggle (div_toggle),
    .div_resetn (div_resetn),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .retry_count(retry_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase number, time spent in phase, edges seen, retries,
  // and the raw input history that the synchronizers delay.
  int m_phase, m_t, m_edges, m_retry;
  bit lock_h [2];
  bit tog_h  [3];

  function automatic void model_reset();
    m_phase = 0; m_t = 0; m_edges = 0; m_retry = 0;
    lock_h = '{0, 0};
    tog_h  = '{0, 0, 0};
  endfunction

  function automatic void model_step(input bit lk, input bit tg);
    bit lock_seen, edge_seen;
    lock_seen = lock_h[1];
    edge_seen = tog_h[1] ^ tog_h[2];
    lock_h[1] = lock_h[0]; lock_h[0] = lk;
    tog_h[2] = tog_h[1]; tog_h[1] = tog_h[0]; tog_h[0] = tg;
    case (m_phase)
      0: m_phase = 1;
      1: if (lock_seen) begin m_phase = 2; m_t = 0; end
      2: if (!lock_seen) m_phase = 1;
         else begin
           m_t++;
           if (m_t == LS) begin m_phase = 3; m_t = 0; end
         end
      3: if (!lock_seen) m_phase = 1;
         else begin
           m_t++;
           if (m_t == DS) begin m_phase = 4; m_t = 0; m_edges = 0; end
         end
      4: if (!lock_seen) m_phase = 1;
         else begin
           m_edges += int'(edge_seen);
           m_t++;
           if (m_edges >= AE) begin m_phase = 5; m_t = 0; end
           else if (m_t == AT) begin m_phase = 1; m_retry = (m_retry < 15) ? m_retry + 1 : 15; end
         end
      default: if (!lock_seen) m_phase = 1;
         else if (edge_seen) m_t = 0;
         else begin
           m_t++;
           if (m_t == AT) begin m_phase = 1; m_retry = (m_retry < 15) ? m_retry + 1 : 15; end
         end
    endcase
  endfunction

  function automatic logic [31:0] model_out();
    logic [2:0] ph;
    logic [3:0] rc;
    ph = 3'(m_phase);
    rc = 4'(m_retry);
    return {22'd0, ph, rc, (m_phase == 5), (m_phase != 5), (m_phase >= 3)};
  endfunction

  function automatic logic [31:0] dut_out();
    return {22'd0, state, retry_count, ready, sys_reset, div_resetn};
  endfunction

  localparam logic [31:0] RESET_VEC = 32'h0000_0002;

  int tog_period = 3;
  int tog_ctr    = 0;
  bit tg_v       = 1'b0;
  bit last_flip  = 1'b0;

  task automatic tick(input bit lk, input bit tg);
    @(negedge clk);
    pll_lock   = lk;
    div_toggle = tg;
    @(posedge clk);
    #1;
    model_step(lk, tg);
    check_val("cycle", dut_out(), model_out());
  endtask

  task automatic step(input bit lk, input bit toggling);
    last_flip = 1'b0;
    if (toggling) begin
      tog_ctr++;
      if (tog_ctr >= tog_period) begin
        tog_ctr   = 0;
        tg_v      = ~tg_v;
        last_flip = 1'b1;
      end
    end
    tick(lk, tg_v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int drop_left, stall_left;
    reset      = 1'b1;
    pll_lock   = 1'b1;
    div_toggle = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_vals", dut_out(), RESET_VEC);
    #1 reset = 1'b0;

    // Nominal bring-up: divider reset releases 1+2+8 edges after first lock sample.
    for (n = 1; n <= 40; n++) begin
      step(1, 1);
      if (div_resetn === 1'b1) break;
    end
    check_val("lock_to_divresetn", 32'(n), 32'd11);
    for (n = 1; n <= 60; n++) begin
      step(1, 1);
      if (ready === 1'b1) break;
    end
    check_val("nominal_ready", 32'(ready), 32'd1);
    check_val("nominal_sysrst", 32'(sys_reset), 32'd0);
    check_val("nominal_retry", 32'(retry_count), 32'd0);
    repeat (10) step(1, 1);

    // Lock loss in RUN: two synchronizer stages plus the FSM edge.
    for (n = 1; n <= 10; n++) begin
      step(0, 1);
      if (ready !== 1'b1) break;
    end
    check_val("lockloss_latency", 32'(n), 32'd3);
    check_val("lockloss_state", 32'(state), 32'd1);
    check_val("lockloss_divrst", 32'(div_resetn), 32'd0);
    check_val("lockloss_sysrst", 32'(sys_reset), 32'd1);
    repeat (4) step(0, 1);

    // Lock glitch partway through the stable count.
    for (n = 1; n <= 50; n++) begin
      step(1, 1);
      if (m_phase == 2 && m_t == 5) break;
    end
    check_val("glitch_reach", 32'(state), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      check_val("glitch_divrst", 32'(div_resetn), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 1);
      check_val("glitch_divrst", 32'(div_resetn), 32'd0);
    end
    for (n = 1; n <= 80; n++) begin
      step(1, 1);
      if (ready === 1'b1) break;
    end
    check_val("glitch_ready", 32'(ready), 32'd1);
    check_val("glitch_retry", 32'(retry_count), 32'd0);

    // Divider stall in RUN: synchronized edge lands 2 edges later, then 16 cycles.
    for (n = 1; n <= 10; n++) begin
      step(1, 1);
      if (last_flip) break;
    end
    for (n = 1; n <= 40; n++) begin
      step(1, 0);
      if (ready !== 1'b1) break;
    end
    check_val("stall_latency", 32'(n), 32'd18);
    check_val("stall_retry", 32'(retry_count), 32'd1);
    check_val("stall_divrst", 32'(div_resetn), 32'd0);

    // Dead divider: repeated CHECK_ALIVE timeouts saturate the retry counter.
    repeat (25 * 29) step(1, 0);
    check_val("dead_retry_sat", 32'(retry_count), 32'd15);
    for (n = 1; n <= 100; n++) begin
      step(1, 1);
      if (ready === 1'b1) break;
    end
    check_val("resume_ready", 32'(ready), 32'd1);

    // Randomized lock drops, divider stalls and toggle rates.
    drop_left  = 0;
    stall_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (drop_left > 0) drop_left--;
      else if ($urandom_range(0, 79) == 0) drop_left = $urandom_range(1, 6);
      if (stall_left > 0) stall_left--;
      else if ($urandom_range(0, 199) == 0) stall_left = $urandom_range(10, 40);
      if ($urandom_range(0, 15) == 0) tog_period = $urandom_range(1, 6);
      step(drop_left == 0, stall_left == 0);
    end

    // Asynchronous reset between clock edges while checking the divider.
    tog_period = 3;
    for (n = 1; n <= 200; n++) begin
      step(1, 1);
      if (m_phase == 4) break;
    end
    check_val("async_reach", 32'(state), 32'd4);
    #2 reset = 1'b1;
    #1;
    check_val("async_reset_vals", dut_out(), RESET_VEC);
    reset = 1'b0;
    model_reset();
    for (n = 1; n <= 80; n++) begin
      step(1, 1);
      if (ready === 1'b1) break;
    end
    check_val("post_async_ready", 32'(ready), 32'd1);
    check_val("post_async_retry", 32'(retry_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clkdiv_reset_sequencer.md
Name: clkdiv_reset_sequencer

Overview:
- Power-up and recovery sequencer for the PLL -> CLKDIV (divide-by-3.5) clock chain.
- Runs on the free-running crystal clock, waits for stable PLL lock, then releases the CLKDIV's active-low reset.
- Confirms the divided clock is toggling, then releases the downstream system reset and asserts ready.
- Re-sequences automatically on lock loss or divided-clock death.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronized lock required before releasing the divider.
- DIV_SETTLE_CYCLES, 16: cycles after divider reset release before alive checking starts.
- ALIVE_TIMEOUT, 256: maximum cycles allowed without a divided-clock toggle edge.
- ALIVE_EDGES, 4: toggle edges required in CHECK_ALIVE before entering RUN.
- CNT_W, 16: width of the shared cycle counter; must hold the largest of the three cycle parameters.

Ports:
- clk, input, 1: free-running reference clock (crystal), the sole clock.
- reset, input, 1: asynchronous, active-high reset.
- pll_lock, input, 1: PLL lock, asynchronous to clk.
- div_toggle, input, 1: toggle flop driven in the divided-clock domain, asynchronous to clk.
- div_resetn, output, 1: active-low reset to the CLKDIV resetn.
- sys_reset, output, 1: active-high reset to divided-clock logic.
- ready, output, 1: chain up and verified.
- retry_count, output, 4: saturating count of alive-check failures.
- state, output, 3: current FSM state encoding, for debug.

Behaviour:
- Reset values: div_resetn=0, sys_reset=1, ready=0, retry_count=0, state=0 (RESET). All synchronizer flops=0 and the counter=0.
- pll_lock passes through a 2-flop synchronizer (lock_s).
- div_toggle passes through a 3-flop synchronizer; an edge is a difference between the last two stages (edge_p, 1-cycle pulse).
- All outputs are registered and computed from next-state, so they change on the same edge as state and never glitch.
- States and transitions:
  - RESET(0): one cycle after reset deassertion -> WAIT_LOCK.
  - WAIT_LOCK(1): when lock_s=1 -> LOCK_STABLE, counter cleared.
  - LOCK_STABLE(2):
    - lock_s=0 -> WAIT_LOCK.
    - Else counter increments; at counter==LOCK_STABLE_CYCLES-1 -> DIV_SETTLE, counter cleared. The state is occupied for exactly LOCK_STABLE_CYCLES cycles.
  - DIV_SETTLE(3):
    - div_resetn=1.
    - lock_s=0 -> WAIT_LOCK.
    - At counter==DIV_SETTLE_CYCLES-1 -> CHECK_ALIVE, counter and edge count cleared.
    - Edges seen here are ignored.
  - CHECK_ALIVE(4):
    - div_resetn=1. Counter counts cycles; edge count increments on edge_p.
    - Edge count reaching ALIVE_EDGES -> RUN, counter cleared.
    - Counter reaching ALIVE_TIMEOUT-1 without enough edges -> WAIT_LOCK and retry_count+1.
    - lock_s=0 -> WAIT_LOCK, no retry increment.
  - RUN(5):
    - div_resetn=1, sys_reset=0, ready=1.
    - Counter clears on every edge_p.
    - counter==ALIVE_TIMEOUT-1 -> WAIT_LOCK and retry_count+1.
    - lock_s=0 -> WAIT_LOCK, no retry increment.
- Output decode by state:
  - div_resetn=1 only in DIV_SETTLE, CHECK_ALIVE, RUN.
  - sys_reset=0 and ready=1 only in RUN.
- Leaving RUN: div_resetn=0, sys_reset=1 and ready=0 all take effect on the same edge as the state change.
- Simultaneous lock loss and timeout: lock loss wins, and retry_count is not incremented.
- retry_count saturates at 15. It is cleared only by reset.
- Asynchronous reset mid-sequence: outputs return to reset values immediately, without waiting for clk.
- Encodings 6 and 7 are unreachable; if entered -> RESET.

Test Plan (LOCK_STABLE_CYCLES=8, DIV_SETTLE_CYCLES=4, ALIVE_TIMEOUT=16, ALIVE_EDGES=2):
- Nominal bring-up: deassert reset, hold pll_lock=1, toggle div_toggle every 3 clk. Required: div_resetn rises at cycle 1+2+8 after first lock sample. ready=1 and sys_reset=0 after 2 synchronized edges in CHECK_ALIVE. retry_count=0.
- Lock glitch: drop pll_lock for 3 cycles at LOCK_STABLE count 5. Required: return to WAIT_LOCK with div_resetn=0 still held. The full 8-cycle stable count restarts after re-lock. retry_count stays 0.
- Dead divider: lock=1, div_toggle static. Required: CHECK_ALIVE times out after 16 cycles, retry_count=1, div_resetn drops to 0, and the sequence repeats. After 20 failures retry_count=15 (saturated).
- Lock loss in RUN: reach ready=1, drop pll_lock. Required: 2 cycles later (sync latency) plus 1 edge, ready=0, sys_reset=1, div_resetn=0, state=1.
- Divider stall in RUN: stop div_toggle. Required: 16 cycles after the last edge, ready=0 and retry_count increments by 1. Resuming toggling re-runs the sequence to RUN.
- Async reset mid-CHECK_ALIVE: pulse reset between clk edges. Required: outputs return immediately to div_resetn=0, sys_reset=1, ready=0, retry_count=0, state=0.
